// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control sequencer: opcodes, ALU function codes
// and the 4-bit binary control-step state encoding.
package cpu_ctrl_pkg;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHL  = 5'b01000;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_MUL = 4'd6;
  localparam logic [3:0] ALU_DIV = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_HALT = 4'd9
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: instruction class flags and ALU function.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             is_alu,
  output logic             is_muldiv,
  output logic             is_nop,
  output logic             is_halt,
  output logic             is_illegal,
  output logic [3:0]       alu_op
);

  // is_alu covers every op that runs T4/T5, so MUL/DIV set both flags.
  always_comb begin
    is_alu     = 1'b0;
    is_muldiv  = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    alu_op     = ALU_ADD;
    case (opcode)
      OPC_ADD:  begin is_alu = 1'b1; alu_op = ALU_ADD; end
      OPC_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB; end
      OPC_AND:  begin is_alu = 1'b1; alu_op = ALU_AND; end
      OPC_OR:   begin is_alu = 1'b1; alu_op = ALU_OR;  end
      OPC_SHR:  begin is_alu = 1'b1; alu_op = ALU_SHR; end
      OPC_SHL:  begin is_alu = 1'b1; alu_op = ALU_SHL; end
      OPC_MUL:  begin is_alu = 1'b1; is_muldiv = 1'b1; alu_op = ALU_MUL; end
      OPC_DIV:  begin is_alu = 1'b1; is_muldiv = 1'b1; alu_op = ALU_DIV; end
      OPC_NOP:  is_nop  = 1'b1;
      OPC_HALT: is_halt = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Control-step sequencer: fetch through PC/MAR/MDR/IR with a memory-ready wait,
// then decode and emit one cycle of datapath strobes per control step.
module ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  dbg_state
);

  state_t state, state_next;
  logic is_alu, is_muldiv, is_nop, is_halt, is_illegal;
  logic [3:0] dec_alu_op;

  // Register-select fields are decoded by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^ir[31-OPC_W:0];

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode     (ir[31 -: OPC_W]),
    .is_alu     (is_alu),
    .is_muldiv  (is_muldiv),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .alu_op     (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_next;
  end

  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = mem_ready ? S_T2 : S_T1W;
      S_T1W:   state_next = mem_ready ? S_T2 : S_T1W;
      S_T2:    state_next = S_T3;
      S_T3: begin
        if (is_alu)       state_next = S_T4;
        else if (is_halt) state_next = S_HALT;
        else              state_next = S_T0;
      end
      S_T4:    state_next = S_T5;
      S_T5:    state_next = is_muldiv ? S_T6 : S_T0;
      S_T6:    state_next = S_T0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0;
    Zlowout = 1'b0; Zhighout = 1'b0; PCin = 1'b0; Read = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; alu_op = 4'd0;
    done = 1'b0; illegal = 1'b0;
    run = (state != S_IDLE) && (state != S_HALT);
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      // Wait cycles keep the read alive but must not reload PC.
      S_T1W: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
        done    = is_nop | is_halt;
        illegal = is_illegal;
      end
      S_T4: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = dec_alu_op; end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1; Rin = 1'b1; done = 1'b1;
        end
      end
      S_T6: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle expected strobe vectors are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_ctrl_sequencer;

  localparam int ST_IDLE = 0, ST_T0 = 1, ST_T1 = 2, ST_T1W = 3, ST_T2 = 4,
                 ST_T3A = 5, ST_T3N = 6, ST_T3I = 7, ST_T4 = 8, ST_T5A = 9,
                 ST_T5M = 10, ST_T6 = 11, ST_HALT = 12;

  localparam logic [31:0] IR_AND  = 32'h28918000;
  localparam logic [31:0] IR_SUB  = 32'h20918000;
  localparam logic [31:0] IR_MUL  = 32'h78918000;
  localparam logic [31:0] IR_DIV  = 32'h80918000;
  localparam logic [31:0] IR_ILL  = 32'hF8918000;
  localparam logic [31:0] IR_NOP  = 32'hD0918000;
  localparam logic [31:0] IR_HALT = 32'hD8918000;
  localparam logic [31:0] IR_OR   = 32'h30918000;
  localparam logic [31:0] IR_ADD  = 32'h18918000;

  logic clk, clr, start, mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout;
  logic IRin, Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout, run, done, illegal;
  logic [3:0] alu_op, dbg_state;

  int checks = 0;
  int errors = 0;
  int pcin_cnt = 0;
  logic [25:0] exp_q[$];
  string name_q[$];

  ctrl_sequencer #(.OPC_W(5)) dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
    .run(run), .done(done), .illegal(illegal), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] exp_vec(input int st, input logic [3:0] aop);
    logic pco, mar, inc, zi, zlo, zho, pci, rd, mdi, mdo, iri, yi, hi, lo;
    logic ga, gb, gc, ri, ro, rn, dn, il;
    logic [3:0] op;
    {pco, mar, inc, zi, zlo, zho, pci, rd, mdi, mdo, iri, yi, hi, lo} = '0;
    {ga, gb, gc, ri, ro, rn, dn, il} = '0;
    op = 4'd0;
    case (st)
      ST_T0:   begin pco = 1; mar = 1; inc = 1; zi = 1; rn = 1; end
      ST_T1:   begin zlo = 1; pci = 1; rd = 1; mdi = 1; rn = 1; end
      ST_T1W:  begin rd = 1; mdi = 1; rn = 1; end
      ST_T2:   begin mdo = 1; iri = 1; rn = 1; end
      ST_T3A:  begin gb = 1; ro = 1; yi = 1; rn = 1; end
      ST_T3N:  begin dn = 1; rn = 1; end
      ST_T3I:  begin il = 1; rn = 1; end
      ST_T4:   begin gc = 1; ro = 1; zi = 1; op = aop; rn = 1; end
      ST_T5A:  begin zlo = 1; ga = 1; ri = 1; dn = 1; rn = 1; end
      ST_T5M:  begin zlo = 1; lo = 1; rn = 1; end
      ST_T6:   begin zho = 1; hi = 1; dn = 1; rn = 1; end
      default: ;
    endcase
    return {pco, mar, inc, zi, zlo, zho, pci, rd, mdi, mdo, iri, yi, hi, lo,
            ga, gb, gc, ri, ro, op, rn, dn, il};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
            MDRout, IRin, Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout, alu_op,
            run, done, illegal};
  endfunction

  // driver tasks
  task automatic cyc(input int st, input logic [3:0] aop, input logic s,
                     input logic mr, input logic c, input string nm);
    @(posedge clk);
    #1;
    start = s; mem_ready = mr; clr = c;
    exp_q.push_back(exp_vec(st, aop));
    name_q.push_back(nm);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fetch(input logic [31:0] iv, input int lows, input string nm);
    cyc(ST_T0, 4'd0, rnd_bit(), rnd_bit(), 1'b0, {nm, "_t0"});
    ir = iv;
    cyc(ST_T1, 4'd0, rnd_bit(), (lows == 0), 1'b0, {nm, "_t1"});
    for (int i = 1; i <= lows; i++)
      cyc(ST_T1W, 4'd0, rnd_bit(), (i == lows), 1'b0, {nm, "_t1w"});
    cyc(ST_T2, 4'd0, rnd_bit(), rnd_bit(), 1'b0, {nm, "_t2"});
  endtask

  task automatic exec_alu(input logic [3:0] aop, input string nm);
    cyc(ST_T3A, 4'd0, rnd_bit(), rnd_bit(), 1'b0, {nm, "_t3"});
    cyc(ST_T4, aop, rnd_bit(), rnd_bit(), 1'b0, {nm, "_t4"});
    cyc(ST_T5A, 4'd0, rnd_bit(), rnd_bit(), 1'b0, {nm, "_t5"});
  endtask

  task automatic exec_muldiv(input logic [3:0] aop, input string nm);
    cyc(ST_T3A, 4'd0, rnd_bit(), rnd_bit(), 1'b0, {nm, "_t3"});
    cyc(ST_T4, aop, rnd_bit(), rnd_bit(), 1'b0, {nm, "_t4"});
    cyc(ST_T5M, 4'd0, rnd_bit(), rnd_bit(), 1'b0, {nm, "_t5"});
    cyc(ST_T6, 4'd0, rnd_bit(), rnd_bit(), 1'b0, {nm, "_t6"});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [25:0] e, g;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      g = dut_vec();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s got=%b want=%b", nm, g, e);
      end
      checks++;
      if (Rin && Rout) begin
        errors++;
        $display("FAIL %s rin_rout got=11 want=not both", nm);
      end
      checks++;
      if ($countones({Gra, Grb, Grc}) > 1) begin
        errors++;
        $display("FAIL %s gr_sel got=%b want=onehot0", nm, {Gra, Grb, Grc});
      end
      if (!run) pcin_cnt = 0;
      else if (PCin) pcin_cnt++;
      if (done || illegal) begin
        checks++;
        if (pcin_cnt != 1) begin
          errors++;
          $display("FAIL %s pcin_count got=%0d want=1", nm, pcin_cnt);
        end
        pcin_cnt = 0;
      end
    end
  end

  initial begin
    clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = 32'h0;
    repeat (2) @(posedge clk);
    cyc(ST_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, "reset_idle");
    cyc(ST_IDLE, 4'd0, 1'b1, 1'b0, 1'b0, "idle_start");
    fetch(IR_AND, 0, "and");
    exec_alu(4'd2, "and");
    fetch(IR_SUB, 3, "sub");
    exec_alu(4'd1, "sub");
    fetch(IR_MUL, 0, "mul");
    exec_muldiv(4'd6, "mul");
    fetch(IR_DIV, 1, "div");
    exec_muldiv(4'd7, "div");
    fetch(IR_ILL, 0, "ill");
    cyc(ST_T3I, 4'd0, rnd_bit(), rnd_bit(), 1'b0, "ill_t3");
    fetch(IR_NOP, 0, "nop");
    cyc(ST_T3N, 4'd0, rnd_bit(), rnd_bit(), 1'b0, "nop_t3");
    fetch(IR_HALT, 0, "halt");
    cyc(ST_T3N, 4'd0, rnd_bit(), rnd_bit(), 1'b0, "halt_t3");
    for (int i = 0; i < 20; i++)
      cyc(ST_HALT, 4'd0, 1'(i % 2), rnd_bit(), 1'b0, "halt_hold");
    cyc(ST_HALT, 4'd0, 1'b1, 1'b1, 1'b1, "halt_clr");
    cyc(ST_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, "post_halt_idle");
    cyc(ST_IDLE, 4'd0, 1'b1, 1'b0, 1'b0, "restart");
    fetch(IR_OR, 0, "or");
    cyc(ST_T3A, 4'd0, 1'b0, 1'b1, 1'b0, "or_t3");
    cyc(ST_T4, 4'd3, 1'b1, 1'b1, 1'b1, "or_t4_clr");
    cyc(ST_IDLE, 4'd0, 1'b0, 1'b1, 1'b0, "clr_idle");
    cyc(ST_IDLE, 4'd0, 1'b1, 1'b0, 1'b0, "restart2");
    fetch(IR_ADD, 0, "add");
    exec_alu(4'd0, "add");
    cyc(ST_T0, 4'd0, 1'b0, 1'b0, 1'b0, "wait_t0");
    cyc(ST_T1, 4'd0, 1'b0, 1'b0, 1'b0, "wait_t1");
    cyc(ST_T1W, 4'd0, 1'b1, 1'b1, 1'b1, "t1w_clr");
    cyc(ST_IDLE, 4'd0, 1'b0, 1'b1, 1'b0, "t1w_clr_idle");
    cyc(ST_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, "final_idle");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Control-step sequencer for the CPU datapath. It replaces hand-driven T0–T5 stimulus with a clocked state machine. It fetches an instruction through PC/MAR/MDR/IR, decodes the IR fields, and emits one cycle of datapath strobes per control step. It supports register-register ALU instructions, MUL/DIV to HI/LO, NOP and HALT, and it waits on a memory-ready handshake during fetch.

## Interface
- Parameters:
- `OPC_W`, 5: opcode field width, IR[31:27].
- Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `start` in 1: leave IDLE and begin fetching at the current PC.
- `ir` in 32: IR register contents. Valid from T3 onward.
- `mem_ready` in 1: memory data on Mdatain is valid this cycle.
- `PCout`, `MARin`, `IncPC`, `Zin`, `Zlowout`, `Zhighout`, `PCin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `HIin`, `LOin` out 1 each: datapath strobes.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout` out 1 each: select-and-encode controls. The datapath decodes IR[26:23], IR[22:19] and IR[18:15].
- `alu_op` out 4: ALU function. Codes: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHL=5, MUL=6, DIV=7.
- `run` out 1: high when not in IDLE or HALT.
- `done` out 1: one-cycle pulse in the final step of each instruction.
- `illegal` out 1: one-cycle pulse in T3 when the opcode is undefined.

## Operation
- Opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, mul 01111, div 10000, nop 11010, halt 11011. All other values are illegal.
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT.
- Strobes are a combinational decode of the registered state, plus `ir` in T3–T6. A strobe is high for the whole cycle; the datapath latches at the closing edge.
- Unlisted strobes are 0. `alu_op` is 0 outside T4.

Per state:
- IDLE: no strobes. Go to T0 if `start`, else stay in IDLE.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin. Go to T2 if `mem_ready`, else T1W.
- T1W: Read, MDRin only. PC is not rewritten. Stay until `mem_ready`, then go to T2.
- T2: MDRout, IRin. Go to T3.
- T3, decoding `ir[31:27]`:
  - ALU op: Grb, Rout, Yin. Go to T4.
  - nop: no strobes. Pulse `done`. Go to T0.
  - halt: no strobes. Pulse `done`. Go to HALT.
  - illegal: no strobes. Pulse `illegal`. Go to T0.
- T4: Grc, Rout, Zin, and `alu_op` from the opcode. Go to T5.
- T5:
  - Non-MUL/DIV: Zlowout, Gra, Rin. Pulse `done`. Go to T0.
  - MUL/DIV: Zlowout, LOin. Go to T6.
- T6: Zhighout, HIin. Pulse `done`. Go to T0.
- HALT: no strobes, `run`=0. Only `clr` exits.
- Execution is continuous: after `done`, the next fetch starts the following cycle with no return to IDLE.
- `start` is ignored outside IDLE.

## Timing
- Reset: `clr` high at an edge forces IDLE. With the state in IDLE, every strobe, `alu_op`, `run`, `done` and `illegal` is 0.
- `clr` wins over every other input, including mid-instruction and during T1W. No partial strobes are emitted in the cycle after reset.
- Cycle counts, from T0 to `done` inclusive, with `mem_ready` high in T1:
  - ALU op: 6 cycles.
  - MUL/DIV: 7 cycles.
  - NOP, HALT, illegal: 4 cycles.
- Each cycle `mem_ready` is low in T1/T1W adds exactly one T1W cycle.
- `mem_ready` is sampled only in T1 and T1W and ignored elsewhere.
- At most one of `Rin`/`Rout` is high in any cycle. At most one of `Gra`/`Grb`/`Grc` is high in any cycle.
- `PCin` is high in exactly one cycle per instruction.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the opcode localparams,
  - the `alu_op` codes,
  - the state encoding, 4-bit binary.
- Sub-module `ctrl_decode`: combinational. Maps `ir[31:27]` to `is_alu`, `is_muldiv`, `is_nop`, `is_halt`, `is_illegal` and `alu_op`.
- The top holds the state register, next-state logic and strobe decode.

## Test plan
- `and R1,R2,R3` (ir=0x28918000), `mem_ready`=1, `start` pulsed at cycle 0 → T0 at cycle 1 through T5 at cycle 6:
  - `alu_op`=2 with Zin in cycle 5,
  - Gra+Rin+`done` in cycle 6,
  - T0 again in cycle 7.
- `sub` (ir=0x20918000) with `mem_ready` low for 3 cycles after T1 → three T1W cycles with Read/MDRin high. PCin high only once. IRin one cycle after `mem_ready` rises. `alu_op`=1.
- `mul` (opcode 01111) → T5 asserts LOin+Zlowout, T6 asserts HIin+Zhighout+`done`. Rin is never asserted.
- ir opcode 11111 → `illegal` pulses in T3, no register strobes, next state T0. ir opcode 11011 → `done` in T3, then `run`=0 with all strobes 0 for 20 cycles despite `start` toggling.
- `clr` asserted during T4 → next cycle is IDLE with all outputs 0. A later `start` fetches from T0 normally.
- Every cycle of every scenario: Rin and Rout never both high, at most one of Gra/Grb/Grc high, and PCin high exactly once per instruction.
